// File: rtl/ingress_rst_seq.sv
// Staged reset/clock-enable sequencer for the ingress core: sync release, clocks, secondary, primary, warm reset.
// Optional quiesce-ack timeout enabled by INGRESS_RST_SEQ_QUIESCE_TIMEOUT_EN.
module ingress_rst_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int CLK_SETTLE_CYC  = 16,
  parameter int STAGE_GAP_CYC   = 8,
  parameter int ASSERT_HOLD_CYC = 4,
  parameter int QUIESCE_TO_CYC  = 256,
  parameter int CNT_W           = 10
) (
  input  logic       primary_clock,
  input  logic       primary_reset_n,
  input  logic       sw_reset_req,
  input  logic       quiesce_ack,
  output logic       enable_primary_clock,
  output logic       enable_secondary_clock,
  output logic       secondary_reset,
  output logic       primary_reset,
  output logic       quiesce_req,
  output logic       reset_done,
  output logic       quiesce_timeout,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_CLKEN   = 3'd1,
    S_SEC_REL = 3'd2,
    S_ACTIVE  = 3'd3,
    S_QUIESCE = 3'd4,
    S_ASSERT  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(CLK_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(STAGE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(ASSERT_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] QTO_LD    = CNT_W'(QUIESCE_TO_CYC - 1);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   timeout_hit;
  logic                   en_nxt, sec_rst_nxt, pri_rst_nxt, qreq_nxt, done_nxt;

  always_ff @(posedge primary_clock or negedge primary_reset_n) begin
    if (!primary_reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge primary_clock or negedge primary_reset_n) begin
    if (!primary_reset_n) begin
      state <= S_RESET;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter is loaded with N-1 on every timed-state entry and idles down elsewhere.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = (cnt != '0) ? cnt - 1'b1 : cnt;
    timeout_hit = 1'b0;
    case (state)
      S_RESET: begin
        if (rst_sync) begin
          state_nxt = S_CLKEN;
          cnt_nxt   = SETTLE_LD;
        end
      end
      S_CLKEN: begin
        if (cnt == '0) begin
          state_nxt = S_SEC_REL;
          cnt_nxt   = GAP_LD;
        end
      end
      S_SEC_REL: begin
        if (cnt == '0) begin
          state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (sw_reset_req) begin
          state_nxt = S_QUIESCE;
          cnt_nxt   = QTO_LD;
        end
      end
      S_QUIESCE: begin
        if (quiesce_ack) begin
          state_nxt = S_ASSERT;
          cnt_nxt   = HOLD_LD;
        end
`ifdef INGRESS_RST_SEQ_QUIESCE_TIMEOUT_EN
        else if (cnt == '0) begin
          state_nxt   = S_ASSERT;
          cnt_nxt     = HOLD_LD;
          timeout_hit = 1'b1;
        end
`endif
      end
      S_ASSERT: begin
        if (cnt == '0) begin
          state_nxt = S_CLKEN;
          cnt_nxt   = SETTLE_LD;
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies track the state register.
  always_comb begin
    en_nxt      = (state_nxt != S_RESET);
    sec_rst_nxt = (state_nxt == S_RESET) || (state_nxt == S_CLKEN) || (state_nxt == S_ASSERT);
    pri_rst_nxt = !((state_nxt == S_ACTIVE) || (state_nxt == S_QUIESCE));
    qreq_nxt    = (state_nxt == S_QUIESCE);
    done_nxt    = (state_nxt == S_ACTIVE) || (state_nxt == S_QUIESCE);
  end

  always_ff @(posedge primary_clock or negedge primary_reset_n) begin
    if (!primary_reset_n) begin
      enable_primary_clock   <= 1'b0;
      enable_secondary_clock <= 1'b0;
      secondary_reset        <= 1'b1;
      primary_reset          <= 1'b1;
      quiesce_req            <= 1'b0;
      reset_done             <= 1'b0;
    end else begin
      enable_primary_clock   <= en_nxt;
      enable_secondary_clock <= en_nxt;
      secondary_reset        <= sec_rst_nxt;
      primary_reset          <= pri_rst_nxt;
      quiesce_req            <= qreq_nxt;
      reset_done             <= done_nxt;
    end
  end

`ifdef INGRESS_RST_SEQ_QUIESCE_TIMEOUT_EN
  always_ff @(posedge primary_clock or negedge primary_reset_n) begin
    if (!primary_reset_n) begin
      quiesce_timeout <= 1'b0;
    end else if (timeout_hit) begin
      quiesce_timeout <= 1'b1;
    end
  end
`else
  assign quiesce_timeout = 1'b0;
`endif

  assign seq_state = state;

endmodule

// File: tb/tb_ingress_rst_seq.sv
// Directed bench for ingress_rst_seq: bring-up timing, warm reset, async abort, held request, quiesce timeout.
module tb_ingress_rst_seq;

  logic       clk;
  logic       rst_n;
  logic       sw_reset_req;
  logic       quiesce_ack;
  logic       enable_primary_clock;
  logic       enable_secondary_clock;
  logic       secondary_reset;
  logic       primary_reset;
  logic       quiesce_req;
  logic       reset_done;
  logic       quiesce_timeout;
  logic [2:0] seq_state;

  int checks = 0;
  int errors = 0;

  ingress_rst_seq dut (
    .primary_clock          (clk),
    .primary_reset_n        (rst_n),
    .sw_reset_req           (sw_reset_req),
    .quiesce_ack            (quiesce_ack),
    .enable_primary_clock   (enable_primary_clock),
    .enable_secondary_clock (enable_secondary_clock),
    .secondary_reset        (secondary_reset),
    .primary_reset          (primary_reset),
    .quiesce_req            (quiesce_req),
    .reset_done             (reset_done),
    .quiesce_timeout        (quiesce_timeout),
    .seq_state              (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {en_p, en_s, sec_rst, pri_rst, qreq, done} for each state.
  function automatic logic [5:0] exp_outs(input logic [2:0] st);
    case (st)
      3'd0:    exp_outs = 6'b00_11_00;
      3'd1:    exp_outs = 6'b11_11_00;
      3'd2:    exp_outs = 6'b11_01_00;
      3'd3:    exp_outs = 6'b11_00_01;
      3'd4:    exp_outs = 6'b11_00_11;
      default: exp_outs = 6'b11_11_00;
    endcase
  endfunction

  // Bring-up edge numbering: release lands before edge 1.
  function automatic logic [2:0] bringup_state(input int e);
    if (e < 3)       bringup_state = 3'd0;
    else if (e < 19) bringup_state = 3'd1;
    else if (e < 27) bringup_state = 3'd2;
    else             bringup_state = 3'd3;
  endfunction

  function automatic logic [5:0] obs_outs();
    obs_outs = {enable_primary_clock, enable_secondary_clock, secondary_reset,
                primary_reset, quiesce_req, reset_done};
  endfunction

  task automatic power_on(input logic sw);
    rst_n = 1'b0;
    sw_reset_req = sw;
    quiesce_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sw_reset_req = 1'b0;
    quiesce_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (seq_state !== 3'd0 || obs_outs() !== 6'b00_11_00 || quiesce_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d outs=%b to=%b, want state=0 outs=001100 to=0",
               seq_state, obs_outs(), quiesce_timeout);
    end
  endtask

  task automatic test_power_on;
    logic [2:0] es;
    power_on(1'b0);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      es = bringup_state(e);
      checks++;
      if (seq_state !== es || obs_outs() !== exp_outs(es)) begin
        errors++;
        $display("FAIL power_on edge %0d: state=%0d outs=%b, want state=%0d outs=%b",
                 e, seq_state, obs_outs(), es, exp_outs(es));
      end
    end
  endtask

  // Entered from S_ACTIVE; request pulse for one cycle, ack seen on the 5th edge after quiesce_req rises.
  task automatic test_warm_reset;
    logic [2:0] es;
    @(negedge clk);
    sw_reset_req = 1'b1;
    @(posedge clk); #1;
    sw_reset_req = 1'b0;
    checks++;
    if (seq_state !== 3'd4 || obs_outs() !== exp_outs(3'd4)) begin
      errors++;
      $display("FAIL warm_enter: state=%0d outs=%b, want state=4 outs=%b",
               seq_state, obs_outs(), exp_outs(3'd4));
    end
    for (int k = 1; k <= 35; k++) begin
      quiesce_ack = (k == 5);
      @(posedge clk); #1;
      if (k < 5)       es = 3'd4;
      else if (k < 9)  es = 3'd5;
      else if (k < 25) es = 3'd1;
      else if (k < 33) es = 3'd2;
      else             es = 3'd3;
      checks++;
      if (seq_state !== es || obs_outs() !== exp_outs(es)) begin
        errors++;
        $display("FAIL warm k=%0d: state=%0d outs=%b, want state=%0d outs=%b",
                 k, seq_state, obs_outs(), es, exp_outs(es));
      end
    end
    quiesce_ack = 1'b0;
  endtask

  task automatic test_async_reset;
    logic [2:0] es;
    for (int run = 0; run < 2; run++) begin
      power_on(1'b0);
      for (int e = 1; e <= 28; e++) begin
        @(posedge clk); #1;
        es = bringup_state(e);
        checks++;
        if (seq_state !== es || obs_outs() !== exp_outs(es)) begin
          errors++;
          $display("FAIL async run%0d edge %0d: state=%0d outs=%b, want state=%0d outs=%b",
                   run, e, seq_state, obs_outs(), es, exp_outs(es));
        end
        if (run == 0 && e == 22) begin
          #2;
          rst_n = 1'b0;
          #1;
          checks++;
          if (seq_state !== 3'd0 || obs_outs() !== 6'b00_11_00) begin
            errors++;
            $display("FAIL async_drop: state=%0d outs=%b, want state=0 outs=001100",
                     seq_state, obs_outs());
          end
          break;
        end
      end
    end
  endtask

  // Request held from power-on; an early ack during S_CLKEN must not skip the quiesce phase.
  task automatic test_sw_held;
    logic [2:0] es;
    power_on(1'b1);
    for (int e = 1; e <= 28; e++) begin
      quiesce_ack = (e >= 5 && e <= 10);
      @(posedge clk); #1;
      es = (e == 28) ? 3'd4 : bringup_state(e);
      checks++;
      if (seq_state !== es || obs_outs() !== exp_outs(es)) begin
        errors++;
        $display("FAIL sw_held edge %0d: state=%0d outs=%b, want state=%0d outs=%b",
                 e, seq_state, obs_outs(), es, exp_outs(es));
      end
    end
    sw_reset_req = 1'b0;
    quiesce_ack = 1'b0;
`ifdef INGRESS_RST_SEQ_QUIESCE_TIMEOUT_EN
    for (int e = 29; e <= 312; e++) begin
      @(posedge clk); #1;
      if (e == 283 || e == 284 || e == 312) begin
        es = (e == 283) ? 3'd4 : (e == 284) ? 3'd5 : 3'd3;
        checks++;
        if (seq_state !== es || quiesce_timeout !== (e != 283)) begin
          errors++;
          $display("FAIL timeout edge %0d: state=%0d to=%b, want state=%0d to=%b",
                   e, seq_state, quiesce_timeout, es, (e != 283));
        end
      end
    end
`else
    repeat (1000) @(posedge clk);
    #1;
    checks++;
    if (seq_state !== 3'd4 || quiesce_req !== 1'b1 || quiesce_timeout !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: state=%0d qreq=%b to=%b, want state=4 qreq=1 to=0",
               seq_state, quiesce_req, quiesce_timeout);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    sw_reset_req = 1'b0;
    quiesce_ack = 1'b0;
    test_reset();
    test_power_on();
    test_warm_reset();
    test_async_reset();
    test_sw_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
